fun_root_mul: RTL
=================

FUN_ROOT_MUL -- requirements
Module: fun_root_mul

Interface
REQ-001 Parameter W, default 8, meaning: width of operands a_i and b_i; legal range 4..16.
REQ-002 Parameter RW, default W+(W+1)/2 (12 for W=8), meaning: result width; it SHALL NOT be overridden below this default.
REQ-003 Port clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  meaning: reset, asynchronous and active-low; the block is in reset while rst=0.
REQ-005 Port start  input  1  meaning: operation request, sampled only in IDLE.
REQ-006 Port mode  input  1  meaning: root select, 0 = integer cube root, 1 = integer square root; sampled with start.
REQ-007 Port a_i  input  W  meaning: unsigned multiplicand; sampled with start.
REQ-008 Port b_i  input  W  meaning: unsigned root operand; sampled with start.
REQ-009 Port busy  output  1  meaning: operation in progress.
REQ-010 Port done  output  1  meaning: one-cycle pulse, result updated this cycle.
REQ-011 Port result  output  RW  meaning: last completed value a*root(b), unsigned.

Function
REQ-012 Result value: result = a * floor(cbrt(b)) for mode=0, or a * floor(sqrt(b)) for mode=1, with a, b and mode captured at acceptance.
REQ-013 Result width: result is exact with no truncation for all W-bit inputs (e.g. W=8: max 255*15=3825 for sqrt, 255*6=1530 for cbrt).
REQ-014 Arithmetic resource: exactly one shared 2W-bit adder; the root and multiply phases time-share it through a state-selected operand mux, and both operands are 0 in IDLE.
REQ-015 Multiply: sequential shift-add of the captured a by the computed root.
REQ-016 Root: sequential digit-by-digit, using only the shared adder, shifts and compares.
REQ-017 FSM states: IDLE, ROOT, MUL, DONE.
REQ-018 Transition IDLE->ROOT on start=1.
REQ-019 Transition ROOT->MUL when the root is complete.
REQ-020 Transition MUL->DONE when the multiply is complete.
REQ-021 Transition DONE->IDLE unconditionally after one cycle.
REQ-022 Acceptance: start=1 in IDLE captures a_i, b_i and mode on that edge; later changes to these inputs do not affect the operation.
REQ-023 start while busy=1 or in DONE: ignored; the request is not queued.
REQ-024 busy timing: busy=1 from the cycle after acceptance through the DONE cycle inclusive; busy=0 in IDLE only.
REQ-025 done timing: done=1 only in DONE, for exactly one cycle per accepted operation; result is written on the edge entering DONE.
REQ-026 Result hold: result keeps its value between completions and changes only on entry to DONE.
REQ-027 Latency: start edge to done pulse is at most 4*W+8 cycles for any inputs and either mode.
REQ-028 Back-to-back: start=1 on the first IDLE cycle after DONE is accepted; the minimum spacing between accepted starts equals the latency plus one cycle.
REQ-029 Zero operands: b=0 gives root=0 and result=0; a=0 gives result=0; both complete normally with a done pulse.
REQ-030 Maximum operand: b=2^W-1 gives the correct floor root (W=8: cbrt=6, sqrt=15).

Reset
REQ-031 While rst=0: state=IDLE, busy=0, done=0, result=0, and all internal datapath registers are cleared.
REQ-032 Reset asserted mid-operation: the operation is aborted immediately (asynchronous), no done pulse is produced, and result=0.
REQ-033 After rst releases: the first start sampled in IDLE is accepted normally.

Verification
REQ-034 Scenario, basic cbrt: W=8, mode=0, a=10, b=27 -> result=30, single done pulse within 40 cycles, busy high throughout.
REQ-035 Scenario, basic sqrt: mode=1, a=255, b=255 -> result=3825; then mode=0, a=255, b=255 -> result=1530.
REQ-036 Scenario, boundaries: b=0 with a=200 -> 0; a=0 with b=64 -> 0; b=63 with mode=0 -> root 3 (a=7 -> 21); b=64 with mode=0 -> root 4 (a=7 -> 28).
REQ-037 Scenario, start while busy: pulse start with new operands mid-operation -> ignored, first result is correct, exactly one done pulse; back-to-back start right after DONE -> accepted.
REQ-038 Scenario, input changes: change a_i, b_i and mode every cycle after acceptance -> result reflects the captured values only.
REQ-039 Scenario, reset mid-operation: assert rst=0 during ROOT, then during MUL -> busy=0, result=0 and no done pulse; the next operation after release is correct.
REQ-040 Exhaustive: W=8, all a, b and both modes -> result matches the reference model and the latency bound of REQ-027 holds.

Source files
------------

// File: rtl/fun_root_mul.sv
// Sequential a * floor(root(b)): digit-by-digit square/cube root followed by a
// shift-add multiply, both time-sharing a single 2W-bit adder.
module fun_root_mul #(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = W + (W + 1) / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result
);

  localparam int unsigned AW  = 2 * W;
  localparam int unsigned ND2 = (W + 1) / 2;
  localparam int unsigned ND3 = (W + 2) / 3;
  localparam int unsigned BW  = W + 2;
  localparam int unsigned SH2 = BW - 2 * ND2;
  localparam int unsigned SH3 = BW - 3 * ND3;
  localparam int unsigned CW  = $clog2(ND2 + 1);

  typedef enum logic [1:0] {IDLE, ROOT, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]  add_a, add_b, sum;
  logic           add_ci;
  logic           neg;

  logic           mode_q, mode_nxt;
  logic [AW-1:0]  ma, ma_nxt;
  logic [BW-1:0]  bsr, bsr_nxt;
  logic [AW-1:0]  rem, rem_nxt;
  logic [AW-1:0]  y, y_nxt;
  logic [AW-1:0]  y2, y2_nxt;
  logic [AW-1:0]  tmp, tmp_nxt;
  logic           ok, ok_nxt;
  logic [1:0]     ph, ph_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [ND2-1:0] mr, mr_nxt;
  logic [RW-1:0]  acc, acc_nxt;
  logic [RW-1:0]  result_nxt;
  logic           busy_nxt, done_nxt;
  logic [AW-1:0]  rem_sh2, rem_sh3;
  logic           last_digit;

  // The one shared adder; subtraction is done as x + ~y + 1.
  assign sum = add_a + add_b + AW'(add_ci);
  assign neg = sum[AW-1];

  // Remainder with the next root digit of b shifted in.
  assign rem_sh2 = {rem[AW-3:0], bsr[BW-1 -: 2]};
  assign rem_sh3 = {rem[AW-4:0], bsr[BW-1 -: 3]};

  always_comb begin
    state_nxt  = state;
    add_a      = '0;
    add_b      = '0;
    add_ci     = 1'b0;
    mode_nxt   = mode_q;
    ma_nxt     = ma;
    bsr_nxt    = bsr;
    rem_nxt    = rem;
    y_nxt      = y;
    y2_nxt     = y2;
    tmp_nxt    = tmp;
    ok_nxt     = ok;
    ph_nxt     = ph;
    cnt_nxt    = cnt;
    mr_nxt     = mr;
    acc_nxt    = acc;
    result_nxt = result;
    last_digit = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ROOT;
          mode_nxt  = mode;
          ma_nxt    = AW'(a_i);
          // Left-align b so the first root digit sits in the top bits.
          bsr_nxt   = mode ? (BW'(b_i) << SH2) : (BW'(b_i) << SH3);
          rem_nxt   = '0;
          y_nxt     = '0;
          y2_nxt    = '0;
          tmp_nxt   = '0;
          ok_nxt    = 1'b0;
          ph_nxt    = 2'd0;
          cnt_nxt   = mode ? CW'(ND2) : CW'(ND3);
          mr_nxt    = '0;
          acc_nxt   = '0;
        end
      end

      ROOT: begin
        if (mode_q) begin
          // Square root: one digit per cycle, trial = 4y+1.
          add_a   = rem_sh2;
          add_b   = ~{y[AW-3:0], 2'b01};
          add_ci  = 1'b1;
          rem_nxt = neg ? rem_sh2 : sum;
          y_nxt   = {y[AW-2:0], ~neg};
          bsr_nxt = bsr << 2;
          cnt_nxt = cnt - CW'(1);
          last_digit = (cnt == CW'(1));
        end else begin
          // Cube root: four adder passes per digit, trial = 12y^2+6y+1.
          ph_nxt = ph + 2'd1;
          case (ph)
            2'd0: begin
              add_a   = {y2[AW-2:0], 1'b0};
              add_b   = y;
              tmp_nxt = sum;
              rem_nxt = rem_sh3;
              bsr_nxt = bsr << 3;
            end
            2'd1: begin
              add_a   = {tmp[AW-3:0], 2'b00};
              add_b   = {tmp[AW-2:0], 1'b0};
              add_ci  = 1'b1;
              tmp_nxt = sum;
            end
            2'd2: begin
              add_a   = rem;
              add_b   = ~tmp;
              add_ci  = 1'b1;
              ok_nxt  = ~neg;
              rem_nxt = neg ? rem : sum;
            end
            default: begin
              // (2y+1)^2 = 4(y^2+y)+1 on accept, (2y)^2 = 4y^2 otherwise.
              add_a   = y2;
              add_b   = y;
              y2_nxt  = ok ? {sum[AW-3:0], 2'b01} : {y2[AW-3:0], 2'b00};
              y_nxt   = {y[AW-2:0], ok};
              cnt_nxt = cnt - CW'(1);
              last_digit = (cnt == CW'(1));
            end
          endcase
        end
        if (last_digit) begin
          state_nxt = MUL;
          mr_nxt    = y_nxt[ND2-1:0];
          acc_nxt   = '0;
        end
      end

      MUL: begin
        add_a   = AW'(acc);
        add_b   = mr[0] ? ma : '0;
        acc_nxt = RW'(sum);
        ma_nxt  = {ma[AW-2:0], 1'b0};
        mr_nxt  = mr >> 1;
        if (mr[ND2-1:1] == '0) begin
          state_nxt  = DONE;
          result_nxt = RW'(sum);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      ma     <= '0;
      bsr    <= '0;
      rem    <= '0;
      y      <= '0;
      y2     <= '0;
      tmp    <= '0;
      ok     <= 1'b0;
      ph     <= 2'd0;
      cnt    <= '0;
      mr     <= '0;
      acc    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      ma     <= ma_nxt;
      bsr    <= bsr_nxt;
      rem    <= rem_nxt;
      y      <= y_nxt;
      y2     <= y2_nxt;
      tmp    <= tmp_nxt;
      ok     <= ok_nxt;
      ph     <= ph_nxt;
      cnt    <= cnt_nxt;
      mr     <= mr_nxt;
      acc    <= acc_nxt;
      result <= result_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule
